scr1_mem_arbiter: RTL and testbench
===================================

// Module: scr1_mem_arbiter
// PURPOSE
//  Shares one SCR1-protocol memory port between the core instruction (imem) and data (dmem) interfaces.
//  Sits between the core and a unified memory or router; both requesters see a normal SCR1 mem port.
//  One transaction in flight; a new request may be accepted in the OKAY response cycle (back-to-back).
//  dmem has fixed priority; a starvation counter forces an imem grant after a run of dmem grants.
// PARAMETERS
//  SCR1_ARB_STARVE_LIMIT  4  consecutive dmem grants with imem waiting before imem is forced; 0 = pure dmem priority
// PORTS
//  rst_n         in   1   async active-low reset
//  clk           in   1   clock, all state on posedge
//  imem_req_ack  out  1   imem request accepted this cycle
//  imem_req      in   1   imem request valid
//  imem_cmd      in   1   0 read, 1 write (imem normally read)
//  imem_addr     in   32  imem byte address
//  imem_rdata    out  32  read data (mem_rdata broadcast)
//  imem_resp     out  2   00 idle, 01 OKAY, 10 ERROR; nonzero only for imem-owned txn
//  dmem_req_ack  out  1   dmem request accepted this cycle
//  dmem_req      in   1   dmem request valid
//  dmem_cmd      in   1   0 read, 1 write
//  dmem_width    in   2   00 byte, 01 half, 10 word
//  dmem_addr     in   32  dmem byte address
//  dmem_wdata    in   32  dmem write data
//  dmem_rdata    out  32  read data (mem_rdata broadcast)
//  dmem_resp     out  2   as imem_resp, dmem-owned txn only
//  mem_req_ack   in   1   shared port accepted request
//  mem_req       out  1   shared port request
//  mem_cmd       out  1   winner cmd
//  mem_width     out  2   winner width; 2'b10 when imem wins
//  mem_addr      out  32  winner address
//  mem_wdata     out  32  dmem_wdata when dmem wins, else 0
//  mem_rdata     in   32  read data
//  mem_resp      in   2   response code
// BEHAVIOUR
//  - Handshake: request transferred when X_req & X_req_ack in one cycle; response is a later cycle with resp!=00.
//  - State: fsm {IDLE, BUSY}, owner_r (0 imem, 1 dmem), starve_cnt [$clog2(LIMIT+1)-1:0].
//  - Reset (async, rst_n=0): fsm=IDLE, owner_r=0, starve_cnt=0.
//    Both *_resp=00, both *_req_ack=0 unless mem_req_ack; mem_req follows the request inputs combinationally.
//  - Arbitration window (arb_en): fsm==IDLE, or fsm==BUSY & mem_resp==01.
//  - Winner (combinational, in window):
//    - dmem if dmem_req & !(imem_req & LIMIT!=0 & starve_cnt==LIMIT);
//    - else imem if imem_req.
//  - In window: mem_req = winner req; mem_cmd/width/addr/wdata = winner fields.
//    Winner X_req_ack = mem_req_ack; loser X_req_ack = 0.
//  - Outside window: mem_req=0, both req_ack=0; mem_* fields still carry the winner mux (don't-care).
//  - IDLE->BUSY on mem_req & mem_req_ack; owner_r <= winner.
//  - BUSY, mem_resp==01:
//    - new handshake -> stay BUSY, owner_r <= new winner;
//    - else -> IDLE.
//  - BUSY, mem_resp==10 -> IDLE; no accept that cycle (arb_en=0). BUSY, mem_resp==00 -> hold.
//  - Response routing: owner_r selects which *_resp = mem_resp; other resp = 00. rdata broadcast to both.
//    Routing uses owner_r before update, so a back-to-back response reaches the old owner.
//  - Responses while IDLE (e.g. stale after reset) are dropped: both resp = 00.
//  - starve_cnt, updated on each handshake:
//    - dmem grant with imem_req=1 -> +1, saturating at LIMIT;
//    - dmem grant with imem_req=0 -> 0;
//    - imem grant -> 0.
//  - Simultaneous imem_req & dmem_req with starve_cnt<LIMIT -> dmem wins; imem held, no ack.
//  - Reset mid-transaction discards ownership; the memory is required to be reset on the same rst_n.
// TESTING
//  - Reset: rst_n=0 with both reqs=1 -> fsm IDLE, imem_resp=dmem_resp=00, starve_cnt=0 after release.
//  - Single imem read A=0x100: ack@T0, mem_resp=01 rdata=0xDEADBEEF @T2
//    -> imem_resp=01 and rdata at T2; dmem_resp=00; mem_width=10.
//  - Collision: both req @T0, mem_req_ack=1 -> dmem_req_ack=1, imem_req_ack=0; mem_addr=dmem_addr, mem_wdata=dmem_wdata.
//  - Back-to-back: dmem txn resp=01 same cycle imem_req & mem_req_ack=1
//    -> dmem_resp=01, imem_req_ack=1, fsm stays BUSY, owner=imem; next 01 goes to imem_resp.
//  - Starvation LIMIT=4: dmem_req and imem_req held high, mem always acks/OKAYs
//    -> grants D,D,D,D,I,D,D,D,D,I; starve_cnt 0..4 then 0.
//  - Error + reset: mem_resp=10 while imem_req=1 & mem_req_ack=1 -> imem_req_ack=0, fsm IDLE;
//    rst_n pulse while BUSY, then mem_resp=01 -> both resp=00.

Source files
------------

// File: rtl/scr1_mem_arbiter.sv
// scr1_mem_arbiter: shares one SCR1 memory port between imem and dmem.
// dmem has fixed priority, bounded by a starvation counter that forces an imem grant.
module scr1_mem_arbiter #(
    parameter int SCR1_ARB_STARVE_LIMIT = 4
) (
    input  logic        rst_n,
    input  logic        clk,
    output logic        imem_req_ack,
    input  logic        imem_req,
    input  logic        imem_cmd,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_rdata,
    output logic [1:0]  imem_resp,
    output logic        dmem_req_ack,
    input  logic        dmem_req,
    input  logic        dmem_cmd,
    input  logic [1:0]  dmem_width,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic [1:0]  dmem_resp,
    input  logic        mem_req_ack,
    output logic        mem_req,
    output logic        mem_cmd,
    output logic [1:0]  mem_width,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  mem_resp
);
    localparam int CW = (SCR1_ARB_STARVE_LIMIT > 0) ? $clog2(SCR1_ARB_STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(SCR1_ARB_STARVE_LIMIT);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_next;
    logic          owner_r;
    logic [CW-1:0] starve_cnt, starve_next;
    logic          arb_en, force_i, win_d, hs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner_r    <= 1'b0;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
            if (hs) owner_r <= win_d;
        end
    end

    always_comb begin
        arb_en       = (state == IDLE) || (mem_resp == 2'b01);
        force_i      = imem_req && (SCR1_ARB_STARVE_LIMIT != 0) && (starve_cnt == LIMIT);
        win_d        = dmem_req && !force_i;
        mem_req      = arb_en && (win_d || imem_req);
        mem_cmd      = win_d ? dmem_cmd : imem_cmd;
        mem_width    = win_d ? dmem_width : 2'b10;
        mem_addr     = win_d ? dmem_addr : imem_addr;
        mem_wdata    = win_d ? dmem_wdata : 32'h0;
        dmem_req_ack = arb_en && win_d && mem_req_ack;
        imem_req_ack = arb_en && !win_d && imem_req && mem_req_ack;
        hs           = mem_req && mem_req_ack;
        // an ERROR or OKAY response ends the transaction unless a new one is accepted
        state_next   = (state == IDLE || mem_resp != 2'b00) ? (hs ? BUSY : IDLE) : BUSY;
        starve_next  = starve_cnt;
        if (hs) starve_next = (win_d && imem_req) ? ((starve_cnt == LIMIT) ? LIMIT : starve_cnt + 1'b1) : '0;
        imem_resp    = (state == BUSY && !owner_r) ? mem_resp : 2'b00;
        dmem_resp    = (state == BUSY && owner_r) ? mem_resp : 2'b00;
        imem_rdata   = mem_rdata;
        dmem_rdata   = mem_rdata;
    end
endmodule

// File: tb/tb_scr1_mem_arbiter.sv
// tb_scr1_mem_arbiter: directed checks of arbitration, routing, starvation, error and reset.
module tb_scr1_mem_arbiter;
    logic        rst_n, clk;
    logic        imem_req_ack, imem_req, imem_cmd;
    logic [31:0] imem_addr, imem_rdata;
    logic [1:0]  imem_resp;
    logic        dmem_req_ack, dmem_req, dmem_cmd;
    logic [1:0]  dmem_width;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [1:0]  dmem_resp;
    logic        mem_req_ack, mem_req, mem_cmd;
    logic [1:0]  mem_width;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_resp;
    int total = 0;
    int bad = 0;
    logic prev_d;

    scr1_mem_arbiter #(.SCR1_ARB_STARVE_LIMIT(4)) dut (
        .rst_n(rst_n), .clk(clk),
        .imem_req_ack(imem_req_ack), .imem_req(imem_req), .imem_cmd(imem_cmd),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .dmem_req_ack(dmem_req_ack), .dmem_req(dmem_req), .dmem_cmd(dmem_cmd),
        .dmem_width(dmem_width), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .mem_req_ack(mem_req_ack), .mem_req(mem_req), .mem_cmd(mem_cmd),
        .mem_width(mem_width), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 0; imem_req = 1; dmem_req = 1; imem_cmd = 0; dmem_cmd = 0;
        imem_addr = 0; dmem_addr = 0; dmem_wdata = 0; dmem_width = 2'b10;
        mem_req_ack = 0; mem_rdata = 0; mem_resp = 0;
        tick(); tick(); #2;
        chk("rst_mem_req", mem_req, 1);
        chk("rst_imem_resp", imem_resp, 0);
        chk("rst_dmem_resp", dmem_resp, 0);
        chk("rst_acks", {imem_req_ack, dmem_req_ack}, 0);
        chk("rst_starve", dut.starve_cnt, 0);
        tick(); rst_n = 1; imem_req = 0; dmem_req = 0;
        // single imem read
        tick(); imem_req = 1; imem_addr = 32'h100; mem_req_ack = 1; #2;
        chk("i_ack", imem_req_ack, 1);
        chk("i_dack", dmem_req_ack, 0);
        chk("i_addr", mem_addr, 32'h100);
        chk("i_width", mem_width, 2'b10);
        chk("i_wdata", mem_wdata, 0);
        tick(); #2;
        chk("busy_noreq", mem_req, 0);
        chk("busy_noack", imem_req_ack, 0);
        tick(); imem_req = 0; mem_req_ack = 0; mem_resp = 2'b01; mem_rdata = 32'hDEADBEEF; #2;
        chk("i_resp", imem_resp, 2'b01);
        chk("i_rdata", imem_rdata, 32'hDEADBEEF);
        chk("i_dresp", dmem_resp, 0);
        chk("d_rdata_bcast", dmem_rdata, 32'hDEADBEEF);
        tick(); mem_resp = 0; #2;
        chk("idle_resp", imem_resp, 0);
        // collision then back-to-back imem
        tick(); imem_req = 1; imem_addr = 32'h104; dmem_req = 1; dmem_addr = 32'h200;
        dmem_wdata = 32'h12345678; dmem_cmd = 1; dmem_width = 2'b01; mem_req_ack = 1; #2;
        chk("c_dack", dmem_req_ack, 1);
        chk("c_iack", imem_req_ack, 0);
        chk("c_addr", mem_addr, 32'h200);
        chk("c_wdata", mem_wdata, 32'h12345678);
        chk("c_width", mem_width, 2'b01);
        chk("c_cmd", mem_cmd, 1);
        tick(); dmem_req = 0; mem_resp = 2'b01; #2;
        chk("b2b_dresp", dmem_resp, 2'b01);
        chk("b2b_iresp", imem_resp, 0);
        chk("b2b_iack", imem_req_ack, 1);
        chk("b2b_addr", mem_addr, 32'h104);
        chk("b2b_starve", dut.starve_cnt, 1);
        tick(); imem_req = 0; mem_req_ack = 0; #2;
        chk("b2b2_iresp", imem_resp, 2'b01);
        chk("b2b2_dresp", dmem_resp, 0);
        chk("b2b2_starve", dut.starve_cnt, 0);
        tick(); mem_resp = 0; imem_req = 1; #2;
        chk("idle_again", mem_req, 1);
        // starvation: D,D,D,D,I,D,D,D,D,I
        dmem_req = 1; mem_req_ack = 1; #1;
        prev_d = 0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                tick(); mem_resp = 2'b01;
            end
            #1;
            chk($sformatf("st_cnt%0d", i), dut.starve_cnt, i % 5);
            chk($sformatf("st_dack%0d", i), dmem_req_ack, (i % 5) != 4);
            chk($sformatf("st_iack%0d", i), imem_req_ack, (i % 5) == 4);
            if (i > 0) chk($sformatf("st_dresp%0d", i), dmem_resp, prev_d ? 2'b01 : 2'b00);
            prev_d = (i % 5) != 4;
        end
        tick(); imem_req = 0; dmem_req = 0; mem_req_ack = 0; #2;
        chk("st_last_iresp", imem_resp, 2'b01);
        chk("st_last_cnt", dut.starve_cnt, 0);
        tick(); mem_resp = 0;
        // error response
        tick(); imem_req = 1; mem_req_ack = 1; #2;
        chk("e_grant", imem_req_ack, 1);
        tick(); mem_resp = 2'b10; #2;
        chk("e_iack", imem_req_ack, 0);
        chk("e_iresp", imem_resp, 2'b10);
        chk("e_memreq", mem_req, 0);
        tick(); mem_resp = 0; mem_req_ack = 0; #2;
        chk("e_idle", mem_req, 1);
        // reset while busy drops the late response
        tick(); mem_req_ack = 1; #2;
        chk("r_grant", imem_req_ack, 1);
        tick(); imem_req = 0; mem_req_ack = 0; rst_n = 0; #2;
        rst_n = 1; mem_resp = 2'b01; #1;
        chk("r_iresp", imem_resp, 0);
        chk("r_dresp", dmem_resp, 0);
        tick(); mem_resp = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
